// File: rtl/safe_sequencer.sv
// Control FSM for the combination safe: debounces-free edge detection of the enter
// button, save strobes for the password/attempt registers, fail counting, lockout and relock.
module safe_sequencer #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 250000000,
  parameter int unsigned RELOCK_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       E,
  input  logic       M,
  output logic       LOCKED,
  output logic       savePW,
  output logic       saveAT,
  output logic [2:0] stateout,
  output logic [3:0] fail_count,
  output logic       lockout
);

  typedef enum logic [2:0] {
    ST_OPEN    = 3'd0,
    ST_LOCKED  = 3'd1,
    ST_LOAD    = 3'd2,
    ST_EVAL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam logic [3:0]  MAX_F        = 4'(MAX_FAILS);
  localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 32'd1);
  localparam logic [31:0] RELOCK_LOAD  = (RELOCK_CYCLES == 32'd0) ? 32'd0 : 32'(RELOCK_CYCLES - 32'd1);
  localparam logic        RELOCK_EN    = (RELOCK_CYCLES != 32'd0);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  fail_q, fail_d;
  logic        savepw_q, savepw_d;
  logic        relock_arm_q, relock_arm_d;
  logic        s1_q, s2_q, prev_q;
  logic        enter_s;
  logic [4:0]  fail_inc_s;

  assign enter_s = s2_q & ~prev_q;

  // State, timer, counter, strobe and synchronizer registers.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_OPEN;
      timer_q      <= 32'd0;
      fail_q       <= 4'd0;
      savepw_q     <= 1'b0;
      relock_arm_q <= 1'b0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      prev_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fail_q       <= fail_d;
      savepw_q     <= savepw_d;
      relock_arm_q <= relock_arm_d;
      s1_q         <= E;
      s2_q         <= s1_q;
      prev_q       <= s2_q;
    end
  end

  // Next-state logic. The relock timer only counts once OPEN was entered by a
  // successful compare; straight out of reset no password exists to relock with.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    fail_d       = fail_q;
    savepw_d     = 1'b0;
    relock_arm_d = relock_arm_q;
    fail_inc_s   = {1'b0, fail_q} + 5'd1;
    case (state_q)
      ST_OPEN: begin
        if (enter_s) begin
          state_d      = ST_LOCKED;
          savepw_d     = 1'b1;
          relock_arm_d = 1'b0;
        end else if (relock_arm_q && (timer_q == 32'd0)) begin
          state_d      = ST_LOCKED;
          relock_arm_d = 1'b0;
        end else if (timer_q != 32'd0) begin
          timer_d = timer_q - 32'd1;
        end else begin
          timer_d = timer_q;
        end
      end
      ST_LOCKED: begin
        if (enter_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOAD: begin
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (M) begin
          state_d      = ST_OPEN;
          fail_d       = 4'd0;
          timer_d      = RELOCK_LOAD;
          relock_arm_d = RELOCK_EN;
        end else if (fail_inc_s >= {1'b0, MAX_F}) begin
          state_d = ST_LOCKOUT;
          fail_d  = MAX_F;
          timer_d = LOCKOUT_LOAD;
        end else begin
          state_d = ST_LOCKED;
          fail_d  = fail_inc_s[3:0];
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == 32'd0) begin
          state_d = ST_LOCKED;
          fail_d  = 4'd0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: begin
        state_d      = ST_OPEN;
        timer_d      = 32'd0;
        fail_d       = 4'd0;
        relock_arm_d = 1'b0;
      end
    endcase
  end

  // Outputs decoded from registers only.
  always_comb begin
    stateout   = state_q;
    LOCKED     = (state_q != ST_OPEN);
    lockout    = (state_q == ST_LOCKOUT);
    saveAT     = (state_q == ST_LOAD);
    savePW     = savepw_q;
    fail_count = fail_q;
  end

endmodule
